// File: rtl/dog_motion_ctrl.sv
// dog_motion_ctrl: tick-paced walk/eat FSM driving the dog sprite position and animation frame
module dog_motion_ctrl #(
  parameter int TICK_MAX  = 4999999,
  parameter int STEP      = 8,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 576,
  parameter int DOG_W     = 64,
  parameter int EAT_TICKS = 8,
  parameter int X_HOME    = 256
) (
  input  logic       pixel_clk,
  input  logic       reset,
  input  logic       eat_req,
  input  logic       left_req,
  input  logic       right_req,
  output logic       ActionS,
  output logic [9:0] DogPos_x1,
  output logic [9:0] DogPos_x2,
  output logic [8:0] DogPos_y,
  output logic [1:0] state,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, WALK_L, WALK_R, EAT} st_e;
  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] MIN_S  = 11'(X_MIN);
  localparam logic signed [10:0] MAX_S  = 11'(X_MAX);
  st_e state_q, state_d;
  logic [22:0] cnt_q, cnt_d;
  logic [3:0] ecnt_q, ecnt_d;
  logic [9:0] x1_q, x1_d;
  logic act_q, act_d;
  logic tick, at_min, at_max;
  logic signed [10:0] x_s, xl, xr;
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ecnt_q  <= '0;
      x1_q    <= 10'(X_HOME);
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ecnt_q  <= ecnt_d;
      x1_q    <= x1_d;
      act_q   <= act_d;
    end
  end
  // 11-bit signed arithmetic so a step past either bound clamps instead of wrapping
  always_comb begin
    tick    = cnt_q == 23'(TICK_MAX);
    cnt_d   = tick ? '0 : cnt_q + 23'd1;
    x_s     = $signed({1'b0, x1_q});
    xl      = x_s - STEP_S;
    xr      = x_s + STEP_S;
    at_min  = x_s <= MIN_S;
    at_max  = x_s >= MAX_S;
    state_d = state_q;
    ecnt_d  = ecnt_q;
    x1_d    = x1_q;
    act_d   = act_q;
    if (tick) begin
      if (state_q == EAT) begin
        state_d = ecnt_q == 4'd0 ? IDLE : EAT;
        act_d   = ecnt_q == 4'd0 ? 1'b0 : ~act_q;
        ecnt_d  = ecnt_q == 4'd0 ? ecnt_q : ecnt_q - 4'd1;
      end else if (eat_req) begin
        state_d = EAT;
        ecnt_d  = 4'(EAT_TICKS - 1);
        act_d   = 1'b1;
      end else if (left_req && !right_req && !at_min) begin
        state_d = WALK_L;
        x1_d    = xl < MIN_S ? 10'(MIN_S) : 10'(xl);
        act_d   = ~act_q;
      end else if (right_req && !left_req && !at_max) begin
        state_d = WALK_R;
        x1_d    = xr > MAX_S ? 10'(MAX_S) : 10'(xr);
        act_d   = ~act_q;
      end else begin
        state_d = IDLE;
        act_d   = 1'b0;
      end
    end
  end
  always_comb begin
    ActionS   = act_q;
    DogPos_x1 = x1_q;
    DogPos_x2 = x1_q + 10'(DOG_W);
    DogPos_y  = 9'd300;
    state     = state_q;
    busy      = state_q == EAT;
  end
endmodule

// File: tb/tb_dog_motion_ctrl.sv
// tb_dog_motion_ctrl: vector table, corner sequences and random stimulus against a tick-level model
module tb_dog_motion_ctrl;
  localparam int STEP = 8, XMIN = 0, XMAX = 576, DOG_W = 64, EATN = 4, HOME = 256;
  logic clk = 0, reset = 0, eat_req = 0, left_req = 0, right_req = 0;
  logic a1, a2, ba, bb;
  logic [9:0] x1a, x2a, x1b, x2b;
  logic [8:0] ya, yb;
  logic [1:0] sa, sb;
  int errors = 0, checks = 0;
  int m_st, m_x, m_act, m_age;
  typedef struct {bit e, l, r; int st, x1, act;} vec_t;
  vec_t v[$];

  always #5 clk = ~clk;

  dog_motion_ctrl #(.TICK_MAX(3), .STEP(STEP), .EAT_TICKS(EATN)) u1 (
    .pixel_clk(clk), .reset(reset), .eat_req(eat_req), .left_req(left_req), .right_req(right_req),
    .ActionS(a1), .DogPos_x1(x1a), .DogPos_x2(x2a), .DogPos_y(ya), .state(sa), .busy(ba));
  dog_motion_ctrl #(.TICK_MAX(3), .STEP(STEP), .EAT_TICKS(EATN), .X_HOME(16)) u2 (
    .pixel_clk(clk), .reset(reset), .eat_req(eat_req), .left_req(left_req), .right_req(right_req),
    .ActionS(a2), .DogPos_x1(x1b), .DogPos_x2(x2b), .DogPos_y(yb), .state(sb), .busy(bb));

  task automatic chk(string n, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", n, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_st = 0; m_x = HOME; m_act = 0; m_age = 0;
  endfunction

  // Eat is modelled by ticks elapsed since entry; frame is 1 on even ages
  function automatic void m_tick(bit e, bit l, bit r);
    if (m_st == 3) begin
      m_age++;
      if (m_age == EATN) begin m_st = 0; m_act = 0; end
      else m_act = (m_age % 2 == 0);
    end else if (e) begin
      m_st = 3; m_age = 0; m_act = 1;
    end else if (l && !r && m_x > XMIN) begin
      m_st = 1; m_x = (m_x - STEP < XMIN) ? XMIN : m_x - STEP; m_act = !m_act;
    end else if (r && !l && m_x < XMAX) begin
      m_st = 2; m_x = (m_x + STEP > XMAX) ? XMAX : m_x + STEP; m_act = !m_act;
    end else begin
      m_st = 0; m_act = 0;
    end
  endfunction

  task automatic check_outs(string t);
    chk({t, "_state"}, sa, m_st);
    chk({t, "_x1"}, x1a, m_x);
    chk({t, "_x2"}, x2a, m_x + DOG_W);
    chk({t, "_y"}, ya, 300);
    chk({t, "_busy"}, ba, m_st == 3);
    chk({t, "_act"}, a1, m_act);
  endtask

  task automatic step_tick(string t);
    repeat (3) begin
      @(posedge clk); #1;
      check_outs({t, "_hold"});
    end
    @(posedge clk); #1;
    m_tick(eat_req, left_req, right_req);
    check_outs(t);
  endtask

  task automatic do_reset();
    reset = 1; eat_req = 0; left_req = 0; right_req = 0;
    @(negedge clk);
    reset = 0;
    m_reset();
  endtask

  initial begin
    #1 reset = 1;
    #2;
    m_reset();
    check_outs("rst");
    chk("rst_x1b", x1b, 16);
    // idle with no requests
    do_reset();
    repeat (10) step_tick("idle");
    chk("idle_x1", x1a, 256);
    chk("idle_x2", x2a, 320);
    chk("idle_y", ya, 300);
    // table: walk right, left+right, all three, eat freeze, re-entry
    v.push_back('{1'b0, 1'b0, 1'b1, 2, 264, 1});
    v.push_back('{1'b0, 1'b0, 1'b1, 2, 272, 0});
    v.push_back('{1'b0, 1'b0, 1'b1, 2, 280, 1});
    v.push_back('{1'b0, 1'b1, 1'b1, 0, 280, 0});
    v.push_back('{1'b1, 1'b1, 1'b1, 3, 280, 1});
    v.push_back('{1'b0, 1'b1, 1'b0, 3, 280, 0});
    v.push_back('{1'b0, 1'b1, 1'b0, 3, 280, 1});
    v.push_back('{1'b0, 1'b1, 1'b0, 3, 280, 0});
    v.push_back('{1'b0, 1'b1, 1'b0, 0, 280, 0});
    v.push_back('{1'b0, 1'b1, 1'b0, 1, 272, 1});
    v.push_back('{1'b1, 1'b0, 1'b0, 3, 272, 1});
    v.push_back('{1'b1, 1'b0, 1'b0, 3, 272, 0});
    v.push_back('{1'b1, 1'b0, 1'b0, 3, 272, 1});
    v.push_back('{1'b1, 1'b0, 1'b0, 3, 272, 0});
    v.push_back('{1'b1, 1'b0, 1'b0, 0, 272, 0});
    v.push_back('{1'b1, 1'b0, 1'b0, 3, 272, 1});
    v.push_back('{1'b0, 1'b0, 1'b0, 3, 272, 0});
    v.push_back('{1'b0, 1'b0, 1'b0, 3, 272, 1});
    v.push_back('{1'b0, 1'b0, 1'b0, 3, 272, 0});
    v.push_back('{1'b0, 1'b0, 1'b0, 0, 272, 0});
    v.push_back('{1'b0, 1'b0, 1'b0, 0, 272, 0});
    do_reset();
    foreach (v[i]) begin
      eat_req = v[i].e; left_req = v[i].l; right_req = v[i].r;
      step_tick($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_vst", i), sa, v[i].st);
      chk($sformatf("tbl%0d_vx1", i), x1a, v[i].x1);
      chk($sformatf("tbl%0d_vact", i), a1, v[i].act);
    end
    // eat pulse that drops before the tick is not latched
    eat_req = 1;
    repeat (2) @(posedge clk);
    #1 eat_req = 0;
    repeat (2) @(posedge clk);
    #1;
    m_tick(1'b0, 1'b0, 1'b0);
    check_outs("glitch");
    // left walk into X_MIN on the home=16 instance
    do_reset();
    left_req = 1;
    step_tick("lw1");
    chk("lw1_st", sb, 1); chk("lw1_x1", x1b, 8); chk("lw1_act", a2, 1);
    step_tick("lw2");
    chk("lw2_st", sb, 1); chk("lw2_x1", x1b, 0); chk("lw2_act", a2, 0); chk("lw2_x2", x2b, 64);
    step_tick("lw3");
    chk("lw3_st", sb, 0); chk("lw3_x1", x1b, 0); chk("lw3_act", a2, 0);
    step_tick("lw4");
    chk("lw4_st", sb, 0); chk("lw4_x1", x1b, 0); chk("lw4_y", yb, 300); chk("lw4_busy", bb, 0);
    // asynchronous reset in the middle of an eat sequence
    left_req = 0; eat_req = 1;
    step_tick("me1");
    eat_req = 0;
    step_tick("me2");
    @(posedge clk);
    #3 reset = 1;
    #1;
    m_reset();
    check_outs("arst");
    @(negedge clk);
    reset = 0;
    right_req = 1;
    step_tick("post");
    chk("post_st", sa, 2);
    chk("post_x1", x1a, 264);
    right_req = 0;
    // random held segments against the model
    do_reset();
    repeat (40) begin
      int k, n;
      k = $urandom_range(0, 9);
      n = $urandom_range(1, 30);
      eat_req = (k == 0);
      left_req = (k >= 1 && k <= 4) || k == 8;
      right_req = (k >= 5);
      repeat (n) step_tick("rnd");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dog_motion_ctrl.md
DOG_MOTION_CTRL -- requirements
Module: dog_motion_ctrl

Interface
REQ-001 Parameter TICK_MAX, default 4999999; animation tick every TICK_MAX+1 clocks.
REQ-002 Parameter STEP, default 8; x-pixels moved per tick while walking.
REQ-003 Parameter X_MIN, default 0; leftmost legal DogPos_x1.
REQ-004 Parameter X_MAX, default 576; rightmost legal DogPos_x1.
REQ-005 Parameter DOG_W, default 64; sprite width; DogPos_x2 = DogPos_x1 + DOG_W.
REQ-006 Parameter EAT_TICKS, default 8; duration of one eat sequence in ticks.
REQ-007 Parameter X_HOME, default 256; DogPos_x1 reset value.
REQ-008 pixel_clk  in  1  sole clock, all state on rising edge.
REQ-009 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-010 eat_req  in  1  level request to start an eat sequence.
REQ-011 left_req  in  1  level request to walk left.
REQ-012 right_req  in  1  level request to walk right.
REQ-013 ActionS  out  1  animation frame select to sprite renderer.
REQ-014 DogPos_x1, DogPos_x2  out  10 each  sprite left/right x-coordinates.
REQ-015 DogPos_y  out  9  sprite y-coordinate, constant 300.
REQ-016 state  out  2  FSM state: 0 IDLE, 1 WALK_L, 2 WALK_R, 3 EAT.
REQ-017 busy  out  1  high while state == EAT.

Function
REQ-018 23-bit prescaler counts 0..TICK_MAX, wraps to 0; tick is a one-cycle pulse when count == TICK_MAX.
REQ-019 All state changes, position updates and ActionS changes occur only on a tick cycle.
REQ-020 Request arbitration on a tick in IDLE, WALK_L or WALK_R: eat_req > left_req > right_req; left_req && right_req both high without eat_req -> IDLE.
REQ-021 IDLE: ActionS = 0; position held; transition per REQ-020.
REQ-022 WALK_L on tick, request still selected: DogPos_x1 -= STEP, clamped to X_MIN; ActionS toggles.
REQ-023 WALK_R on tick, request still selected: DogPos_x1 += STEP, clamped to X_MAX; ActionS toggles.
REQ-024 A clamped move (result hits X_MIN/X_MAX) -> IDLE on the next tick; a walk request already at the bound produces no move and state IDLE.
REQ-025 Entering WALK_L/WALK_R from IDLE moves on that same tick per REQ-022/023.
REQ-026 Position arithmetic in 11 bits with signed compare before clamping; no 10-bit wrap-around permitted.
REQ-027 EAT entry: loads 4-bit eat counter with EAT_TICKS-1, ActionS = 1, position frozen.
REQ-028 In EAT on each tick: ActionS toggles, counter decrements; tick with counter == 0 -> IDLE, ActionS = 0.
REQ-029 EAT is non-preemptible: eat_req, left_req, right_req ignored until EAT exits; eat_req still high at exit re-enters EAT on the next tick, not the exit tick.
REQ-030 Requests deasserted between ticks are not latched; only levels sampled on the tick count.
REQ-031 DogPos_x2 combinational from DogPos_x1 + DOG_W; DogPos_y tied to 300.

Reset
REQ-032 On reset: state IDLE, prescaler 0, eat counter 0, ActionS 0, DogPos_x1 X_HOME (x2 = X_HOME+DOG_W), busy 0.
REQ-033 Reset asserted mid-walk or mid-eat aborts immediately; first tick after release occurs TICK_MAX+1 clocks later.

Verification (TICK_MAX=3, STEP=8, EAT_TICKS=4 unless stated)
REQ-034 Reset, no requests, 40 clocks -> state 0, ActionS 0, x1=256, x2=320, y=300 throughout.
REQ-035 right_req held 3 ticks -> x1 264, 272, 280 on successive ticks; ActionS 1,0,1; state 2.
REQ-036 X_HOME=16, left_req held -> x1 8, 0 (clamped), then state 0, x1 stays 0, ActionS 0.
REQ-037 eat_req pulse then left_req high during EAT -> busy 4 ticks, ActionS 1,0,1,0, x1 frozen 256, then WALK_L on following tick.
REQ-038 eat_req, left_req, right_req all high -> EAT chosen; left+right only -> IDLE, x1 unchanged.
REQ-039 reset asserted mid-EAT between clock edges -> outputs take REQ-032 values without waiting for a clock edge.
